// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared state type and default widths for the divided-clock monitor
package clk_mon_pkg;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} clk_mon_state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchroniser for an asynchronous level plus a rising-edge pulse
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);
    logic r_s1, r_s2, r_s3;
    always_ff @(posedge i_clk) begin
        if (i_rst) {r_s1, r_s2, r_s3} <= '0;
        else       {r_s1, r_s2, r_s3} <= {i_d, r_s1, r_s2};
    end
    assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: measures the period of a divided clock sampled as data, tracks lock and faults
module clock_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int EXP_PERIOD = 100,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clock1M,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             err_clr,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             error
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [GW-1:0]    LOCK_V = GW'(LOCK_COUNT);
    if (EXP_PERIOD + TOL >= 2 ** CNT_W || TOL >= EXP_PERIOD) begin : g_bad_params
        $error("clock_monitor: EXP_PERIOD+TOL must fit CNT_W and TOL must be below EXP_PERIOD");
    end
    clk_mon_state_t   r_state;
    logic [CNT_W-1:0] r_cnt, r_period, w_meas;
    logic [GW-1:0]    r_good;
    logic             r_pv, r_err, w_tick, w_in_tol;
    sync_edge_det u_sync (
        .i_clk (clock1M),
        .i_rst (reset),
        .i_d   (clk_in),
        .o_rise(w_tick)
    );
    // saturating cnt+1 doubles as both the measured period and the next count
    assign w_meas   = &r_cnt ? r_cnt : r_cnt + 1'b1;
    assign w_in_tol = (w_meas >= MIN_P) && (w_meas <= MAX_P);
    always_ff @(posedge clock1M) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_good   <= '0;
            r_period <= '0;
            r_pv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_pv  <= 1'b0;
            r_cnt <= (r_state == IDLE || w_tick) ? '0 : w_meas;
            if (err_clr) r_err <= 1'b0;
            case (r_state)
                IDLE: if (w_tick) r_state <= MEASURE;
                MEASURE, LOCKED: begin
                    if (w_tick) begin
                        r_period <= w_meas;
                        r_pv     <= 1'b1;
                        if (!w_in_tol) begin
                            r_good  <= '0;
                            r_err   <= 1'b1;
                            r_state <= MEASURE;
                        end else if (r_state == MEASURE) begin
                            r_good <= r_good + 1'b1;
                            if (r_good + 1'b1 == LOCK_V) r_state <= LOCKED;
                        end
                    end else if (r_cnt == MAX_P) begin
                        r_good  <= '0;
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign tick         = w_tick;
    assign period       = r_period;
    assign period_valid = r_pv;
    assign locked       = (r_state == LOCKED);
    assign error        = r_err;
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed run of a 10 kHz and a 100 kHz monitor with an edge-event scoreboard
module tb_clock_monitor;
    localparam int EXP = 100, TOL = 1, LOCKN = 4, MAXP = EXP + TOL;
    typedef struct {int c; int p;} exp_t;
    logic clk = 1'b0, rst = 1'b1, clk_in = 1'b0, clk_in_f = 1'b0, err_clr = 1'b0;
    logic tick, pv, locked, error, tick_f, pv_f, locked_f, error_f;
    logic [15:0] period, period_f;
    logic prev_seen = 1'b0, lk_f_prev = 1'b0;
    int n_assert = 0, n_fail = 0, cyc = 0;
    int gen_p = 0, ph = 0, gen_f = 0, ph_f = 0, last_edge = -1;
    int m_state = 0, m_last = 0, m_good = 0, m_lock_cyc = -1;
    int last_f = -1, nt_f = 0, lock_f = -1;
    int q_tick[$];
    exp_t q_pv[$];
    clock_monitor #(.CNT_W(16), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_COUNT(LOCKN)) dut (
        .clock1M(clk), .reset(rst), .clk_in(clk_in), .err_clr(err_clr), .tick(tick),
        .period(period), .period_valid(pv), .locked(locked), .error(error)
    );
    clock_monitor #(.CNT_W(16), .EXP_PERIOD(10), .TOL(1), .LOCK_COUNT(4)) dut_f (
        .clock1M(clk), .reset(rst), .clk_in(clk_in_f), .err_clr(1'b0), .tick(tick_f),
        .period(period_f), .period_valid(pv_f), .locked(locked_f), .error(error_f)
    );
    always #1 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask
    // Event-level reference: one call per synchronised rising edge, t = cycle its tick shows
    task automatic model_tick(input int t);
        int p;
        if (m_state != 0 && t - m_last > MAXP + 1) begin
            m_state = 0;
            m_good  = 0;
        end
        if (m_state == 0) m_state = 1;
        else begin
            p = t - m_last;
            q_pv.push_back('{t + 1, p});
            if (p >= EXP - TOL && p <= MAXP) begin
                if (m_state == 1) begin
                    m_good++;
                    if (m_good == LOCKN) begin
                        m_state    = 2;
                        m_lock_cyc = t + 1;
                    end
                end
            end else begin
                m_good  = 0;
                m_state = 1;
            end
        end
        m_last = t;
        q_tick.push_back(t);
    endtask
    task automatic step();
        exp_t e;
        int et;
        @(negedge clk);
        cyc++;
        if (tick === 1'b1 || (q_tick.size() > 0 && q_tick[0] <= cyc)) begin
            et = -1;
            if (q_tick.size() > 0) et = q_tick.pop_front();
            chk("tick_cycle", tick ? cyc : 0, et);
        end
        if (pv === 1'b1 || (q_pv.size() > 0 && q_pv[0].c <= cyc)) begin
            e = '{-1, -1};
            if (q_pv.size() > 0) e = q_pv.pop_front();
            chk("pv_cycle", pv ? cyc : 0, e.c);
            if (pv) chk("period", period, e.p);
        end
        if (tick_f === 1'b1) begin
            if (last_f >= 0) chk("tick_spacing_f", cyc - last_f, 10);
            last_f = cyc;
            nt_f++;
            if (nt_f == 5) lock_f = cyc + 1;
        end
        if (pv_f === 1'b1) chk("period_f", period_f, 10);
        if (cyc == lock_f) chk("lock_rise_f", {locked_f, lk_f_prev}, 2'b10);
        lk_f_prev = locked_f;
        if (gen_p > 0) begin
            clk_in = (ph < gen_p / 2);
            ph = (ph + 1) % gen_p;
        end else clk_in = 1'b0;
        if (!rst && clk_in && !prev_seen) begin
            last_edge = cyc;
            model_tick(cyc + 2);
        end
        prev_seen = rst ? 1'b0 : clk_in;
        if (gen_f > 0) begin
            clk_in_f = (ph_f < gen_f / 2);
            ph_f = (ph_f + 1) % gen_f;
        end else clk_in_f = 1'b0;
    endtask
    task automatic wait_edge();
        int k = 0;
        do begin
            step();
            k++;
        end while (last_edge != cyc && k < 300);
        chk("edge_wait", last_edge == cyc, 1);
    endtask
    task automatic run_until_lock(input int limit);
        int k = 0;
        while (locked !== 1'b1 && k < limit) begin
            step();
            k++;
        end
        chk("lock_reached", locked, 1);
        chk("lock_cycle", cyc, m_lock_cyc);
    endtask
    task automatic start_reset();
        gen_p = 0;
        gen_f = 0;
        rst = 1'b1;
        q_tick.delete();
        q_pv.delete();
        m_state = 0;
        m_good = 0;
        m_lock_cyc = -1;
        prev_seen = 1'b0;
        last_f = -1;
        nt_f = 0;
        lock_f = -1;
    endtask
    task automatic release_reset();
        rst = 1'b0;
        ph = 0;
        ph_f = 0;
        gen_p = EXP;
        gen_f = 10;
    endtask
    initial begin
        int t;
        start_reset();
        repeat (2) step();
        chk("rst_outs", {tick, pv, locked, error, period}, 0);
        chk("rst_outs_f", {tick_f, pv_f, locked_f, error_f, period_f}, 0);
        release_reset();
        run_until_lock(700);
        chk("lock_no_error", error, 0);
        chk("lock_period", period, EXP);
        gen_p = 0;
        while (cyc < m_last + MAXP + 1) step();
        chk("pre_timeout", {locked, error}, 2'b10);
        step();
        chk("timeout", {locked, error}, 2'b01);
        repeat (10) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr_alone", error, 0);
        ph = 0;
        gen_p = EXP;
        run_until_lock(700);
        wait_edge();
        gen_p = 90;
        wait_edge();
        gen_p = EXP;
        repeat (4) step();
        chk("drift_flags", {locked, error}, 2'b01);
        chk("drift_period", period, 90);
        run_until_lock(700);
        chk("relock_err_sticky", error, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr_after_relock", error, 0);
        wait_edge();
        gen_p = 90;
        t = last_edge + 92;
        while (cyc < t) step();
        chk("bad_tick_now", tick, 1);
        gen_p = EXP;
        err_clr = 1'b1;
        step();
        chk("set_beats_clr", error, 1);
        step();
        chk("clr_next_cycle", error, 0);
        err_clr = 1'b0;
        run_until_lock(700);
        start_reset();
        step();
        chk("midrst_outs", {tick, pv, locked, error, period}, 0);
        chk("midrst_locked_f", locked_f, 0);
        step();
        release_reset();
        run_until_lock(700);
        chk("relock_no_error", error, 0);
        repeat (20) step();
        chk("fast_locked", locked_f, 1);
        chk("fast_no_error", error_f, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
